// File: rtl/task_answer_uart_packetizer_pkg.sv
// Shared types for the task answer UART packetizer: read-FSM states, descriptor layout,
// and the header byte selector.
package task_answer_uart_packetizer_pkg;

  typedef enum logic [1:0] {StIdle, StHdr, StPay, StDrain} answer_tx_state_t;

  localparam int unsigned HdrLen   = 9;
  // Wide enough for any supported FIFO depth (up to 32768 words).
  localparam int unsigned WordCntW = 16;

  typedef struct packed {
    logic [31:0]         size;
    logic [31:0]         latency;
    logic [WordCntW-1:0] words;
  } answer_desc_t;

  function automatic logic [7:0] hdr_byte(input logic [3:0]  idx,
                                          input logic [7:0]  sync,
                                          input logic [31:0] size,
                                          input logic [31:0] latency);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = sync;
      4'd1:    b = size[7:0];
      4'd2:    b = size[15:8];
      4'd3:    b = size[23:16];
      4'd4:    b = size[31:24];
      4'd5:    b = latency[7:0];
      4'd6:    b = latency[15:8];
      4'd7:    b = latency[23:16];
      4'd8:    b = latency[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/task_answer_uart_packetizer_if.sv
// Answer stream in, UART byte stream out. The master side produces answers and consumes bytes.
interface task_answer_uart_packetizer_if;
  logic        answer_valid;
  logic [31:0] answer_data;
  logic        answer_last;
  logic [31:0] answer_size_in_bytes;
  logic [31:0] answer_latency;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output answer_valid, answer_data, answer_last, answer_size_in_bytes, answer_latency,
    output tx_ready,
    input  tx_data, tx_valid
  );

  modport slave (
    input  answer_valid, answer_data, answer_last, answer_size_in_bytes, answer_latency,
    input  tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/task_answer_uart_packetizer_word_buffer.sv
// Payload word FIFO whose write side commits a whole packet on its last word or rewinds to the
// packet start, so the reader only ever sees complete packets.
module task_answer_uart_packetizer_word_buffer #(
  parameter int unsigned Depth = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [31:0]              wr_data,
  input  logic                     wr_last,
  input  logic                     desc_full,
  output logic                     commit,
  output logic [$clog2(Depth):0]   commit_words,
  output logic                     drop,
  input  logic                     rd_en,
  output logic [31:0]              rd_data
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [31:0] mem [Depth];
  logic [Aw:0] wr_ptr_q, rd_ptr_q, pkt_start_q, pkt_words_q;
  logic        pkt_bad_q;
  logic        full, accept;

  always_comb begin
    full         = (wr_ptr_q - rd_ptr_q) == (Aw+1)'(Depth);
    // A same-cycle read frees a slot before the write lands.
    accept       = wr_valid && (!full || rd_en);
    commit       = wr_valid && wr_last && accept && !pkt_bad_q && !desc_full;
    drop         = wr_valid && wr_last && !commit;
    commit_words = pkt_words_q + (Aw+1)'(1);
    rd_data      = mem[rd_ptr_q[Aw-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_start_q <= '0;
      pkt_words_q <= '0;
      pkt_bad_q   <= 1'b0;
    end else begin
      if (rd_en) rd_ptr_q <= rd_ptr_q + (Aw+1)'(1);
      if (wr_valid && wr_last) begin
        pkt_bad_q   <= 1'b0;
        pkt_words_q <= '0;
        if (commit) begin
          wr_ptr_q    <= wr_ptr_q + (Aw+1)'(1);
          pkt_start_q <= wr_ptr_q + (Aw+1)'(1);
        end else begin
          wr_ptr_q <= pkt_start_q;
        end
      end else if (wr_valid) begin
        if (accept) begin
          wr_ptr_q    <= wr_ptr_q + (Aw+1)'(1);
          pkt_words_q <= pkt_words_q + (Aw+1)'(1);
        end else begin
          pkt_bad_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q[Aw-1:0]] <= wr_data;
  end

endmodule

// File: rtl/task_answer_uart_packetizer.sv
// Buffers whole task answer packets and emits them as UART bytes: 9-byte header, then the
// payload LSB-first, trimmed or zero-padded to the reported byte count.
module task_answer_uart_packetizer
  import task_answer_uart_packetizer_pkg::*;
#(
  parameter int unsigned FifoDepth = 256,
  parameter int unsigned DescDepth = 4,
  parameter logic [7:0]  SyncByte  = 8'hA5
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  task_answer_uart_packetizer_if.slave  bus,
  output logic                          o_busy,
  output logic                          o_overflow
);

  localparam int unsigned Aw  = $clog2(FifoDepth);
  localparam int unsigned Daw = $clog2(DescDepth);

  logic          commit, drop, rd_en;
  logic [Aw:0]   commit_words;
  logic [31:0]   rd_data;

  answer_desc_t  desc_mem [DescDepth];
  answer_desc_t  desc_head;
  logic [Daw:0]  dwr_q, drd_q;
  logic          desc_full, desc_empty, pop;

  answer_tx_state_t    state_q, state_d;
  logic [31:0]         size_q, size_d, lat_q, lat_d, bytes_left_q, bytes_left_d;
  logic [WordCntW-1:0] words_left_q, words_left_d;
  logic [3:0]          idx_q, idx_d;
  logic [1:0]          lane_q, lane_d;
  logic                overflow_q;

  task_answer_uart_packetizer_word_buffer #(
    .Depth (FifoDepth)
  ) u_word_buffer (
    .clk          (i_clk),
    .rst_n        (i_rst),
    .wr_valid     (bus.answer_valid),
    .wr_data      (bus.answer_data),
    .wr_last      (bus.answer_last),
    .desc_full    (desc_full),
    .commit       (commit),
    .commit_words (commit_words),
    .drop         (drop),
    .rd_en        (rd_en),
    .rd_data      (rd_data)
  );

  assign desc_full  = (dwr_q - drd_q) == (Daw+1)'(DescDepth);
  assign desc_empty = (dwr_q == drd_q);
  assign desc_head  = desc_mem[drd_q[Daw-1:0]];
  assign o_busy     = !desc_empty || (state_q != StIdle);
  assign o_overflow = overflow_q;

  always_ff @(posedge i_clk) begin
    if (commit) begin
      desc_mem[dwr_q[Daw-1:0]] <= '{size:    bus.answer_size_in_bytes,
                                    latency: bus.answer_latency,
                                    words:   WordCntW'(commit_words)};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      dwr_q        <= '0;
      drd_q        <= '0;
      overflow_q   <= 1'b0;
      state_q      <= StIdle;
      size_q       <= '0;
      lat_q        <= '0;
      bytes_left_q <= '0;
      words_left_q <= '0;
      idx_q        <= '0;
      lane_q       <= '0;
    end else begin
      if (commit) dwr_q <= dwr_q + (Daw+1)'(1);
      if (pop)    drd_q <= drd_q + (Daw+1)'(1);
      if (drop)   overflow_q <= 1'b1;
      state_q      <= state_d;
      size_q       <= size_d;
      lat_q        <= lat_d;
      bytes_left_q <= bytes_left_d;
      words_left_q <= words_left_d;
      idx_q        <= idx_d;
      lane_q       <= lane_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    lat_d        = lat_q;
    bytes_left_d = bytes_left_q;
    words_left_d = words_left_q;
    idx_d        = idx_q;
    lane_d       = lane_q;
    pop          = 1'b0;
    rd_en        = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (!desc_empty) begin
          pop          = 1'b1;
          size_d       = desc_head.size;
          lat_d        = desc_head.latency;
          words_left_d = desc_head.words;
          idx_d        = '0;
          state_d      = StHdr;
        end
      end
      StHdr: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = hdr_byte(idx_q, SyncByte, size_q, lat_q);
        if (bus.tx_ready) begin
          if (idx_q == 4'(HdrLen - 1)) begin
            idx_d        = '0;
            lane_d       = '0;
            bytes_left_d = size_q;
            state_d      = (size_q == 32'd0) ? StDrain : StPay;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StPay: begin
        bus.tx_valid = 1'b1;
        // Bytes beyond the buffered words are padded with zero.
        bus.tx_data  = (words_left_q == '0) ? 8'h00 : 8'(rd_data >> {lane_q, 3'b000});
        if (bus.tx_ready) begin
          bytes_left_d = bytes_left_q - 32'd1;
          lane_d       = lane_q + 2'd1;
          if (words_left_q != '0 && (lane_q == 2'd3 || bytes_left_q == 32'd1)) begin
            rd_en        = 1'b1;
            words_left_d = words_left_q - WordCntW'(1);
          end
          if (bytes_left_q == 32'd1) state_d = StDrain;
        end
      end
      StDrain: begin
        if (words_left_q != '0) begin
          rd_en        = 1'b1;
          words_left_d = words_left_q - WordCntW'(1);
        end
        if (words_left_q <= WordCntW'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_task_answer_uart_packetizer.sv
// Directed bench for the task answer UART packetizer: byte stream, back-pressure, padding,
// overflow, descriptor-queue exhaustion and mid-packet reset.
module tb_task_answer_uart_packetizer;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, overflow;
  logic ready_const = 1'b1;
  logic ready_toggle = 1'b0;
  logic tog = 1'b1;
  logic stab_en = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  got_q [$];
  logic [7:0]  exp_q [$];
  logic [31:0] wq    [$];

  task_answer_uart_packetizer_if bus ();

  task_answer_uart_packetizer #(
    .FifoDepth (256),
    .DescDepth (4),
    .SyncByte  (8'hA5)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .bus        (bus),
    .o_busy     (busy),
    .o_overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tog <= ~tog;
  assign bus.tx_ready = ready_toggle ? tog : ready_const;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stab_en && prev_stall)
      check_eq("stall_hold", {23'b0, bus.tx_valid, bus.tx_data}, {23'b0, 1'b1, prev_data});
    prev_stall = bus.tx_valid && !bus.tx_ready;
    prev_data  = bus.tx_data;
    if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
  end

  task automatic send_pkt(input logic [31:0] size, input logic [31:0] lat);
    for (int i = 0; i < wq.size(); i++) begin
      bus.answer_valid         = 1'b1;
      bus.answer_data          = wq[i];
      bus.answer_last          = (i == wq.size() - 1);
      bus.answer_size_in_bytes = size;
      bus.answer_latency       = lat;
      @(posedge clk); #1;
    end
    bus.answer_valid = 1'b0;
    bus.answer_last  = 1'b0;
    wq.delete();
  endtask

  task automatic push_hdr(input logic [31:0] size, input logic [31:0] lat);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) exp_q.push_back(size[8*i +: 8]);
    for (int i = 0; i < 4; i++) exp_q.push_back(lat[8*i +: 8]);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || bus.tx_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check_eq("idle_timeout", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check_eq({tag, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_t1();
    logic [7:0] t1 [15];
    t1 = '{8'hA5, 8'h06, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
           8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (t1[i]) exp_q.push_back(t1[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bus.answer_valid         = 1'b0;
    bus.answer_data          = '0;
    bus.answer_last          = 1'b0;
    bus.answer_size_in_bytes = '0;
    bus.answer_latency       = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
    check_eq("rst_tx_data",  {24'b0, bus.tx_data},  32'd0);
    check_eq("rst_busy",     {31'b0, busy},         32'd0);
    check_eq("rst_overflow", {31'b0, overflow},     32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single packet, ready held high
    wq = '{32'h44332211, 32'h88776655};
    send_pkt(32'd6, 32'h10);
    wait_idle(200);
    push_t1();
    compare_stream("t1");

    // 2: same packet with ready toggling every cycle
    ready_toggle = 1'b1;
    stab_en      = 1'b1;
    wq = '{32'h44332211, 32'h88776655};
    send_pkt(32'd6, 32'h10);
    wait_idle(400);
    stab_en      = 1'b0;
    ready_toggle = 1'b0;
    push_t1();
    compare_stream("t2");

    // 3: header-only packet, then a padded packet
    wq = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567};
    send_pkt(32'd0, 32'h20);
    wq = '{32'h04030201, 32'h08070605};
    send_pkt(32'd9, 32'h01);
    wait_idle(400);
    exp_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00,
              8'hA5, 8'h09, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00};
    compare_stream("t3");
    check_eq("t3_no_overflow", {31'b0, overflow}, 32'd0);

    // 4: oversize packet is dropped, the following one survives
    for (int i = 0; i < 300; i++) wq.push_back(32'h1000 + i);
    send_pkt(32'd1200, 32'h05);
    check_eq("t4_overflow", {31'b0, overflow}, 32'd1);
    check_eq("t4_not_busy", {31'b0, busy},     32'd0);
    wq = '{32'hDDCCBBAA};
    send_pkt(32'd4, 32'h07);
    wait_idle(200);
    exp_q = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00,
              8'hAA, 8'hBB, 8'hCC, 8'hDD};
    compare_stream("t4");

    // 5: descriptor queue exhaustion; packet 1 moves straight into the transmitter,
    // packets 2-5 fill the 4-entry queue, packet 6 is dropped
    do_reset();
    check_eq("t5_rst_overflow", {31'b0, overflow}, 32'd0);
    ready_const = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      wq = '{32'hC0 + k};
      send_pkt(32'd1, k);
    end
    check_eq("t5_overflow", {31'b0, overflow}, 32'd1);
    check_eq("t5_busy",     {31'b0, busy},     32'd1);
    ready_const = 1'b1;
    wait_idle(400);
    for (int k = 1; k <= 5; k++) begin
      push_hdr(32'd1, k);
      exp_q.push_back(8'(8'hC0 + k));
    end
    compare_stream("t5");

    // 6: reset in the middle of the payload
    wq = '{32'h44332211, 32'h88776655};
    send_pkt(32'd8, 32'h33);
    n = 0;
    while (got_q.size() < 11 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_mid_pay", {31'b0, got_q.size() >= 11}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("t6_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
    check_eq("t6_busy",     {31'b0, busy},         32'd0);
    check_eq("t6_overflow", {31'b0, overflow},     32'd0);
    rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    wq = '{32'h44332211, 32'h88776655};
    send_pkt(32'd6, 32'h10);
    wait_idle(200);
    push_t1();
    compare_stream("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
